icarus_test: RTL and testbench

- Free-running, enable-gated up-counter used as a simulator/toolflow smoke-test block.
- Increments an unsigned count on each rising clock edge while enabled, and holds otherwise.
- Wraps modulo 2^WIDTH.
- Purely synchronous, single clock domain; no handshakes.

---
 rtl/icarus_test.sv | 21 ++
 tb/tb_icarus_test.sv | 106 ++++++++++
 2 files changed

// File: rtl/icarus_test.sv
// Enable-gated up-counter with synchronous active-low reset, used as a toolflow smoke test.
// Wraps modulo 2^WIDTH; count comes straight from the register.
module icarus_test #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Reset wins over enable; the carry out of the increment is dropped, giving the wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_icarus_test.sv
// Scoreboard bench for icarus_test: stimulus queues the expected count for each edge,
// a monitor compares the DUT just after every rising edge.
module tb_icarus_test;

  typedef struct {
    logic [7:0] value;
    string      name;
  } expect_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] count;

  expect_t exp_q[$];
  int      checks = 0;
  int      errors = 0;
  bit      stim_done = 0;

  icarus_test #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; the value due after the next rising edge is queued.
  task automatic step(input logic r, input logic e, input logic [7:0] value, input string name);
    expect_t item;
    @(negedge clk);
    rst_n = r;
    en    = e;
    item.value = value;
    item.name  = name;
    exp_q.push_back(item);
  endtask

  initial begin
    expect_t item;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        item = exp_q.pop_front();
        checks++;
        if (count !== item.value) begin
          errors++;
          $display("[TB] FAIL %s: count=%0d expected=%0d at %0t", item.name, count, item.value, $time);
        end
      end
    end
  end

  initial begin
    logic [7:0] v;
    rst_n = 1'b0;
    en    = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd0, "reset");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'd0, "hold");
    for (int i = 1; i <= 20; i++) begin
      v = 8'(i);
      step(1'b1, 1'b1, v, "count");
    end

    step(1'b0, 1'b1, 8'd0, "reset_before_pause");
    for (int i = 1; i <= 7; i++) begin
      v = 8'(i);
      step(1'b1, 1'b1, v, "count_to_7");
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd7, "pause");
    step(1'b1, 1'b1, 8'd8, "resume");
    step(1'b1, 1'b1, 8'd9, "resume");

    step(1'b0, 1'b0, 8'd0, "reset_before_wrap");
    for (int i = 1; i <= 255; i++) begin
      v = 8'(i);
      step(1'b1, 1'b1, v, "wrap_climb");
    end
    step(1'b1, 1'b1, 8'd0, "wrap_to_zero");
    step(1'b1, 1'b1, 8'd1, "after_wrap");

    step(1'b0, 1'b0, 8'd0, "reset_before_prio");
    for (int i = 1; i <= 100; i++) begin
      v = 8'(i);
      step(1'b1, 1'b1, v, "count_to_100");
    end
    step(1'b0, 1'b1, 8'd0, "reset_priority");
    step(1'b1, 1'b1, 8'd1, "resume_after_reset");
    step(1'b1, 1'b0, 8'd1, "hold_after_reset");

    stim_done = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
